// File: rtl/alu_share_if.sv
// Bundle of the two request ports, the ALU side, the response slot and the
// grant counters of alu_share_arbiter. The slave modport is the arbiter's view.
interface alu_share_if #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [SEL_W-1:0]  req0_sel;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [SEL_W-1:0]  req1_sel;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [SEL_W-1:0]  alu_sel;
    logic [DATA_W-1:0] alu_c;
    logic              alu_cf;
    logic              alu_sf;
    logic              alu_zf;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_cf;
    logic              rsp_sf;
    logic              rsp_zf;

    logic [CNT_W-1:0]  grant_cnt0;
    logic [CNT_W-1:0]  grant_cnt1;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sel,
        input  req1_valid, req1_a, req1_b, req1_sel,
        input  alu_c, alu_cf, alu_sf, alu_zf,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_sel,
        output rsp_valid, rsp_id, rsp_data, rsp_cf, rsp_sf, rsp_zf,
        output grant_cnt0, grant_cnt1
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sel,
        output req1_valid, req1_a, req1_b, req1_sel,
        output alu_c, alu_cf, alu_sf, alu_zf,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_sel,
        input  rsp_valid, rsp_id, rsp_data, rsp_cf, rsp_sf, rsp_zf,
        input  grant_cnt0, grant_cnt1
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two requesters, with a
// single registered response slot tagged by requester id and per-port grant counters.
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int SEL_W  = 3,
    parameter int CNT_W  = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_share_if.slave    bus
);
    logic slot_free;
    logic grant_valid;
    logic grant_id;
    logic last_grant;
    logic xfer;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = ~last_grant;
        end else if (bus.req0_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b0;
        end else if (bus.req1_valid) begin
            grant_valid = 1'b1;
            grant_id    = 1'b1;
        end
    end

    // The slot can take a new result when empty or being drained this cycle.
    assign slot_free      = !bus.rsp_valid || bus.rsp_ready;
    assign xfer           = grant_valid && slot_free && !rst;
    assign bus.req0_ready = xfer && !grant_id;
    assign bus.req1_ready = xfer && grant_id;

    always_comb begin
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        bus.alu_sel = '0;
        if (grant_valid) begin
            bus.alu_a   = grant_id ? bus.req1_a   : bus.req0_a;
            bus.alu_b   = grant_id ? bus.req1_b   : bus.req0_b;
            bus.alu_sel = grant_id ? bus.req1_sel : bus.req0_sel;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rsp_valid  <= 1'b0;
            bus.rsp_id     <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_cf     <= 1'b0;
            bus.rsp_sf     <= 1'b0;
            bus.rsp_zf     <= 1'b0;
            bus.grant_cnt0 <= '0;
            bus.grant_cnt1 <= '0;
            last_grant     <= 1'b1;
        end else if (xfer) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= grant_id;
            bus.rsp_data  <= bus.alu_c;
            bus.rsp_cf    <= bus.alu_cf;
            bus.rsp_sf    <= bus.alu_sf;
            bus.rsp_zf    <= bus.alu_zf;
            last_grant    <= grant_id;
            if (grant_id) bus.grant_cnt1 <= bus.grant_cnt1 + 1'b1;
            else          bus.grant_cnt0 <= bus.grant_cnt0 + 1'b1;
        end else if (bus.rsp_ready) begin
            // Drain only: data and flags keep their last value.
            bus.rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a reference ALU, a cycle model with a response
// scoreboard, a table of per-cycle vectors and hand-written corner sequences.
module tb_alu_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_share_if #(.DATA_W(32), .SEL_W(3), .CNT_W(16)) bus ();
    alu_share_arbiter #(.DATA_W(32), .SEL_W(3), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference ALU: carry on add, borrow on sub, zero result for undefined opcodes.
    typedef struct packed {
        logic [31:0] c;
        logic        cf;
        logic        sf;
        logic        zf;
    } alu_res_t;

    function automatic alu_res_t alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
        alu_res_t    r;
        logic [32:0] w;
        w = '0;
        case (s)
            3'b000:  w = {1'b0, a} + {1'b0, b};
            3'b001:  w = {1'b0, a << b[4:0]};
            3'b010:  w = {1'b0, a} - {1'b0, b};
            3'b100:  w = {1'b0, a ^ b};
            3'b101:  w = {1'b0, a >> b[4:0]};
            3'b110:  w = {1'b0, a | b};
            3'b111:  w = {1'b0, a & b};
            default: w = '0;
        endcase
        r.c  = w[31:0];
        r.cf = (s == 3'b000 || s == 3'b010) ? w[32] : 1'b0;
        r.sf = w[31];
        r.zf = (w[31:0] == 32'h0);
        return r;
    endfunction

    alu_res_t alu_r;
    assign alu_r      = alu_fn(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.alu_c  = alu_r.c;
    assign bus.alu_cf = alu_r.cf;
    assign bus.alu_sf = alu_r.sf;
    assign bus.alu_zf = alu_r.zf;

    typedef struct packed {
        logic     id;
        alu_res_t r;
    } exp_t;
    exp_t q[$];

    // Cycle model: checked at every falling edge, then advanced to the next cycle.
    logic        m_last    = 1'b1;
    logic        exp_valid = 1'b0;
    logic        exp_hold  = 1'b0;
    logic [15:0] m_cnt0    = '0;
    logic [15:0] m_cnt1    = '0;
    logic        hold_id;
    logic [31:0] hold_data;
    logic [2:0]  hold_flags;
    bit          mon_en    = 1'b0;

    always @(negedge clk) begin : monitor
        logic g_v, g_id, m_r0, m_r1, free;
        exp_t e;
        if (mon_en) begin
            check("rsp_valid", bus.rsp_valid, exp_valid);
            check("grant_cnt0", bus.grant_cnt0, m_cnt0);
            check("grant_cnt1", bus.grant_cnt1, m_cnt1);
            if (exp_hold) begin
                check("hold_data", bus.rsp_data, hold_data);
                check("hold_id", bus.rsp_id, hold_id);
                check("hold_flags", {bus.rsp_cf, bus.rsp_sf, bus.rsp_zf}, hold_flags);
            end
            free = !exp_valid || bus.rsp_ready;
            g_v  = bus.req0_valid || bus.req1_valid;
            g_id = (bus.req0_valid && bus.req1_valid) ? ~m_last : bus.req1_valid;
            m_r0 = !rst && g_v && !g_id && free;
            m_r1 = !rst && g_v && g_id && free;
            check("ready0", bus.req0_ready, m_r0);
            check("ready1", bus.req1_ready, m_r1);
            if (!rst && bus.rsp_valid && bus.rsp_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_pop: response seen with scoreboard empty (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    check("sb_id", bus.rsp_id, e.id);
                    check("sb_data", bus.rsp_data, e.r.c);
                    check("sb_flags", {bus.rsp_cf, bus.rsp_sf, bus.rsp_zf}, {e.r.cf, e.r.sf, e.r.zf});
                end
            end
            if (rst) begin
                q.delete();
                m_last    = 1'b1;
                m_cnt0    = '0;
                m_cnt1    = '0;
                exp_valid = 1'b0;
                exp_hold  = 1'b0;
            end else begin
                exp_hold   = exp_valid && !bus.rsp_ready && !(m_r0 || m_r1);
                hold_id    = bus.rsp_id;
                hold_data  = bus.rsp_data;
                hold_flags = {bus.rsp_cf, bus.rsp_sf, bus.rsp_zf};
                if (m_r0) begin
                    q.push_back({1'b0, alu_fn(bus.req0_a, bus.req0_b, bus.req0_sel)});
                    m_last = 1'b0;
                    m_cnt0 = m_cnt0 + 16'd1;
                end
                if (m_r1) begin
                    q.push_back({1'b1, alu_fn(bus.req1_a, bus.req1_b, bus.req1_sel)});
                    m_last = 1'b1;
                    m_cnt1 = m_cnt1 + 16'd1;
                end
                exp_valid = m_r0 || m_r1 || (exp_valid && !bus.rsp_ready);
            end
        end
    end

    task automatic drive(input logic r,
                         input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] s0,
                         input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] s1,
                         input logic rr);
        @(posedge clk);
        #1;
        rst            = r;
        bus.req0_valid = v0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req0_sel   = s0;
        bus.req1_valid = v1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.req1_sel   = s1;
        bus.rsp_ready  = rr;
    endtask

    typedef struct {
        logic        r;
        logic        v0;
        logic [31:0] a0, b0;
        logic [2:0]  s0;
        logic        v1;
        logic [31:0] a1, b1;
        logic [2:0]  s1;
        logic        rr;
        logic        exp_r0, exp_r1;
        logic [31:0] exp_alu_a;
        logic [2:0]  exp_alu_sel;
    } vec_t;

    vec_t vecs[11];

    initial begin
        // Reset held with both valid, then contention alternating from req0, then req0 alone, then idle.
        for (int i = 0; i < 3; i++)
            vecs[i] = '{1'b1, 1'b1, 32'd7, 32'd7, 3'b010, 1'b1, 32'h0F, 32'd4, 3'b001, 1'b1, 1'b0, 1'b0, 32'd7, 3'b010};
        for (int i = 3; i < 9; i++)
            vecs[i] = '{1'b0, 1'b1, 32'd7, 32'd7, 3'b010, 1'b1, 32'h0F, 32'd4, 3'b001, 1'b1,
                        (i % 2 == 1), (i % 2 == 0),
                        (i % 2 == 1) ? 32'd7 : 32'h0F, (i % 2 == 1) ? 3'b010 : 3'b001};
        vecs[9]  = '{1'b0, 1'b1, 32'd5, 32'd3, 3'b000, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b1, 1'b0, 32'd5, 3'b000};
        vecs[10] = '{1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd0, 3'b000};

        rst            = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sel = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sel = '0;
        bus.rsp_ready  = 1'b0;
        mon_en         = 1'b1;

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].r, vecs[i].v0, vecs[i].a0, vecs[i].b0, vecs[i].s0,
                  vecs[i].v1, vecs[i].a1, vecs[i].b1, vecs[i].s1, vecs[i].rr);
            @(negedge clk);
            check($sformatf("vec%0d_ready0", i), bus.req0_ready, vecs[i].exp_r0);
            check($sformatf("vec%0d_ready1", i), bus.req1_ready, vecs[i].exp_r1);
            check($sformatf("vec%0d_alu_a", i), bus.alu_a, vecs[i].exp_alu_a);
            check($sformatf("vec%0d_alu_sel", i), bus.alu_sel, vecs[i].exp_alu_sel);
        end
        check("cnt0_after_table", bus.grant_cnt0, 16'd4);
        check("cnt1_after_table", bus.grant_cnt1, 16'd3);
        check("add_5_3_data", bus.rsp_data, 32'd8);
        check("add_5_3_id", bus.rsp_id, 1'b0);
        check("add_5_3_flags", {bus.rsp_cf, bus.rsp_sf, bus.rsp_zf}, 3'b000);

        // Backpressure: req1 wins (req0 went last), then slot held for 4 cycles.
        drive(1'b0, 1'b1, 32'd1, 32'd2, 3'b000, 1'b1, 32'h10, 32'd4, 3'b101, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 32'd1, 32'd2, 3'b000, 1'b1, 32'h10, 32'd4, 3'b101, 1'b0);
            @(negedge clk);
            check("bp_ready0", bus.req0_ready, 1'b0);
            check("bp_ready1", bus.req1_ready, 1'b0);
            check("bp_data", bus.rsp_data, 32'h1);
            check("bp_id", bus.rsp_id, 1'b1);
        end
        drive(1'b0, 1'b1, 32'd1, 32'd2, 3'b000, 1'b1, 32'h10, 32'd4, 3'b101, 1'b1);
        @(negedge clk);
        check("bp_release_ready0", bus.req0_ready, 1'b1);
        check("bp_release_ready1", bus.req1_ready, 1'b0);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b000, 1'b1);
        @(negedge clk);
        check("refill_valid", bus.rsp_valid, 1'b1);
        check("refill_data", bus.rsp_data, 32'd3);
        check("refill_id", bus.rsp_id, 1'b0);

        // Carry-out wrap on req1, then an undefined opcode passed straight through.
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1, 32'd5, 32'd3, 3'b011, 1'b1);
        @(negedge clk);
        check("wrap_data", bus.rsp_data, 32'h0);
        check("wrap_cf", bus.rsp_cf, 1'b1);
        check("wrap_zf", bus.rsp_zf, 1'b1);
        check("wrap_id", bus.rsp_id, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        @(negedge clk);
        check("op011_data", bus.rsp_data, 32'h0);
        check("op011_id", bus.rsp_id, 1'b1);

        // Reset the cycle after an acceptance discards the pending response.
        drive(1'b0, 1'b1, 32'd9, 32'd1, 3'b000, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        drive(1'b1, 1'b1, 32'd2, 32'd2, 3'b000, 1'b1, 32'd3, 32'd3, 3'b000, 1'b0);
        @(negedge clk);
        check("rst_mid_valid", bus.rsp_valid, 1'b1);
        check("rst_mid_ready0", bus.req0_ready, 1'b0);
        drive(1'b0, 1'b1, 32'd2, 32'd2, 3'b000, 1'b1, 32'd3, 32'd3, 3'b000, 1'b1);
        @(negedge clk);
        check("post_rst_valid", bus.rsp_valid, 1'b0);
        check("post_rst_ready0", bus.req0_ready, 1'b1);
        check("post_rst_ready1", bus.req1_ready, 1'b0);
        check("post_rst_cnt0", bus.grant_cnt0, 16'd0);

        for (int i = 0; i < 3; i++)
            drive(1'b0, 1'b0, 32'd0, 32'd0, 3'b000, 1'b0, 32'd0, 32'd0, 3'b000, 1'b1);
        @(negedge clk);
        check("sb_drained", q.size(), 64'd0);
        check("final_cnt0", bus.grant_cnt0, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
